// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types for the decode-stage register file and scoreboard.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0]        regbits_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_sb_if.sv
// Signal bundle for the register file with scoreboard; rf faces the design, tb faces the driver.
interface register_file_sb_if #(
    parameter int NREGS  = 32,
    parameter int WORD_W = 32
) (
    input logic CLK
);
    localparam int SEL_W = $clog2(NREGS);

    logic              nRST;
    logic              WEN;
    logic [SEL_W-1:0]  wsel;
    logic [WORD_W-1:0] wdat;
    logic [SEL_W-1:0]  rsel1;
    logic [SEL_W-1:0]  rsel2;
    logic [WORD_W-1:0] rdat1;
    logic [WORD_W-1:0] rdat2;
    logic              iss_en;
    logic [SEL_W-1:0]  iss_sel;
    logic              busy1;
    logic              busy2;
    logic [SEL_W:0]    pend_cnt;

    modport rf (
        input  CLK, nRST, WEN, wsel, wdat, rsel1, rsel2, iss_en, iss_sel,
        output rdat1, rdat2, busy1, busy2, pend_cnt
    );

    modport tb (
        input  CLK, rdat1, rdat2, busy1, busy2, pend_cnt,
        output nRST, WEN, wsel, wdat, rsel1, rsel2, iss_en, iss_sel
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-writer flags, busy lookup and registered pending count.
// Optional REGFILE_BYPASS_EN: a same-cycle writeback to the read register masks busy.
module reg_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       wen,
    input  logic [$clog2(NREGS)-1:0]   wsel,
    input  logic                       iss_en,
    input  logic [$clog2(NREGS)-1:0]   iss_sel,
    input  logic [$clog2(NREGS)-1:0]   rsel1,
    input  logic [$clog2(NREGS)-1:0]   rsel2,
    output logic                       busy1,
    output logic                       busy2,
    output logic [$clog2(NREGS):0]     pend_cnt
);
    import cpu_types_pkg::*;

    localparam int CNT_W = $clog2(NREGS) + 1;

    logic [NREGS-1:0] pending;
    logic             wr_hit;
    logic             iss_hit;
    logic             cnt_inc;
    logic             cnt_dec;

    assign wr_hit  = wen && (wsel != REG_ZERO);
    assign iss_hit = iss_en && (iss_sel != REG_ZERO);

    // A clear is cancelled when the same edge re-issues that register.
    assign cnt_inc = iss_hit && !pending[iss_sel];
    assign cnt_dec = wr_hit && pending[wsel] && !(iss_hit && (iss_sel == wsel));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_hit) begin
                pending[wsel] <= 1'b0;
            end
            if (iss_hit) begin
                pending[iss_sel] <= 1'b1;
            end
            pend_cnt <= pend_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        end
    end

    always_comb begin
        busy1 = pending[rsel1];
        busy2 = pending[rsel2];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (rsel1 == wsel)) begin
            busy1 = 1'b0;
        end
        if (wr_hit && (rsel2 == wsel)) begin
            busy2 = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/register_file_sb.sv
// 2R1W MIPS register file (r0 hard-wired to zero) with pending-write scoreboard.
// Optional REGFILE_BYPASS_EN: write-first bypass of wdat onto matching read ports.
module register_file_sb #(
    parameter int NREGS  = 32,
    parameter int WORD_W = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       WEN,
    input  logic [$clog2(NREGS)-1:0]   wsel,
    input  logic [WORD_W-1:0]          wdat,
    input  logic [$clog2(NREGS)-1:0]   rsel1,
    input  logic [$clog2(NREGS)-1:0]   rsel2,
    output logic [WORD_W-1:0]          rdat1,
    output logic [WORD_W-1:0]          rdat2,
    input  logic                       iss_en,
    input  logic [$clog2(NREGS)-1:0]   iss_sel,
    output logic                       busy1,
    output logic                       busy2,
    output logic [$clog2(NREGS):0]     pend_cnt
);
    import cpu_types_pkg::*;

    logic [WORD_W-1:0] regs [NREGS];
    logic              wr_hit;

    assign wr_hit = WEN && (wsel != REG_ZERO);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wsel] <= wdat;
        end
    end

    always_comb begin
        rdat1 = (rsel1 == REG_ZERO) ? '0 : regs[rsel1];
        rdat2 = (rsel2 == REG_ZERO) ? '0 : regs[rsel2];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (rsel1 == wsel)) begin
            rdat1 = wdat;
        end
        if (wr_hit && (rsel2 == wsel)) begin
            rdat2 = wdat;
        end
`endif
    end

    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .CLK      (CLK),
        .nRST     (nRST),
        .wen      (WEN),
        .wsel     (wsel),
        .iss_en   (iss_en),
        .iss_sel  (iss_sel),
        .rsel1    (rsel1),
        .rsel2    (rsel2),
        .busy1    (busy1),
        .busy2    (busy2),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: tb/tb_register_file_sb.sv
// Self-checking bench for register_file_sb: directed plan steps followed by random traffic vs. an array model.
module tb_register_file_sb;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    register_file_sb_if rf (.CLK(CLK));

    register_file_sb dut (
        .CLK      (CLK),
        .nRST     (rf.nRST),
        .WEN      (rf.WEN),
        .wsel     (rf.wsel),
        .wdat     (rf.wdat),
        .rsel1    (rf.rsel1),
        .rsel2    (rf.rsel2),
        .rdat1    (rf.rdat1),
        .rdat2    (rf.rdat2),
        .iss_en   (rf.iss_en),
        .iss_sel  (rf.iss_sel),
        .busy1    (rf.busy1),
        .busy2    (rf.busy2),
        .pend_cnt (rf.pend_cnt)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    word_t m_regs [32];
    bit    m_pend [32];

    localparam bit BYPASS =
`ifdef REGFILE_BYPASS_EN
        1'b1;
`else
        1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit wr_collides(input logic [4:0] r);
        return BYPASS && rf.WEN && (rf.wsel != 5'd0) && (rf.wsel == r);
    endfunction

    function automatic word_t exp_rdat(input logic [4:0] r);
        if (r == 5'd0) return '0;
        if (wr_collides(r)) return rf.wdat;
        return m_regs[r];
    endfunction

    function automatic bit exp_busy(input logic [4:0] r);
        if (wr_collides(r)) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic check_comb(input string tag);
        chk({tag, ".rdat1"}, rf.rdat1, exp_rdat(rf.rsel1));
        chk({tag, ".rdat2"}, rf.rdat2, exp_rdat(rf.rsel2));
        chk({tag, ".busy1"}, {31'd0, rf.busy1}, {31'd0, exp_busy(rf.rsel1)});
        chk({tag, ".busy2"}, {31'd0, rf.busy2}, {31'd0, exp_busy(rf.rsel2)});
    endtask

    task automatic drive(input logic wen, input logic [4:0] ws, input word_t wd,
                         input logic ie, input logic [4:0] is, input logic [4:0] r1,
                         input logic [4:0] r2);
        rf.WEN = wen; rf.wsel = ws; rf.wdat = wd;
        rf.iss_en = ie; rf.iss_sel = is;
        rf.rsel1 = r1; rf.rsel2 = r2;
    endtask

    // Advance one edge: update the model from the inputs held across it, then check.
    task automatic step(input string tag);
        @(posedge CLK);
        if (!rf.nRST) begin
            model_clear();
        end else begin
            if (rf.WEN && rf.wsel != 5'd0) begin
                m_regs[rf.wsel] = rf.wdat;
                m_pend[rf.wsel] = 1'b0;
            end
            if (rf.iss_en && rf.iss_sel != 5'd0) m_pend[rf.iss_sel] = 1'b1;
        end
        #1;
        chk({tag, ".pend_cnt"}, {26'd0, rf.pend_cnt}, 32'(model_count()));
        check_comb(tag);
    endtask

    initial begin
        int prev_cnt;
        logic [4:0] ws, is;
        model_clear();
        rf.nRST = 1'b0;
        drive(0, 0, '0, 0, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #1;
        rf.nRST = 1'b1;

        // Reset state across all registers
        chk("reset.pend_cnt", {26'd0, rf.pend_cnt}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, '0, 0, 0, 5'(i), 5'(31 - i));
            #1;
            check_comb("reset");
        end

        // Write reg 5, read back; write to r0 ignored
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step("wr5");
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 5, 0);
        #1;
        chk("rd5.const", rf.rdat1, 32'hDEADBEEF);
        step("wr0");
        chk("rd0.const", rf.rdat2, 32'h0);

        // Issue 7 then 9, then writeback 7
        drive(0, 0, '0, 1, 7, 7, 9);
        step("iss7");
        chk("iss7.cnt", {26'd0, rf.pend_cnt}, 32'd1);
        drive(0, 0, '0, 1, 9, 7, 9);
        step("iss9");
        chk("iss9.cnt", {26'd0, rf.pend_cnt}, 32'd2);
        chk("iss9.busy1", {31'd0, rf.busy1}, 32'd1);
        drive(1, 7, 32'h0000_0777, 0, 0, 7, 9);
        step("wb7");
        drive(0, 0, '0, 0, 0, 7, 9);
        #1;
        chk("wb7.busy1", {31'd0, rf.busy1}, 32'd0);
        chk("wb7.cnt", {26'd0, rf.pend_cnt}, 32'd1);

        // Same-edge issue and write to 12 (already pending): set wins, count unchanged
        drive(0, 0, '0, 1, 12, 12, 12);
        step("iss12");
        prev_cnt = int'(rf.pend_cnt);
        drive(1, 12, 32'h0000_1234, 1, 12, 12, 0);
        step("wi12");
        drive(0, 0, '0, 0, 0, 12, 0);
        #1;
        chk("wi12.rdat", rf.rdat1, 32'h0000_1234);
        chk("wi12.busy", {31'd0, rf.busy1}, 32'd1);
        chk("wi12.cnt", {26'd0, rf.pend_cnt}, 32'(prev_cnt));

        // Writeback/read collision on reg 3 with an outstanding issue
        drive(1, 3, 32'h1111_1111, 1, 3, 0, 0);
        step("prep3");
        drive(1, 3, 32'hA5A5A5A5, 0, 0, 0, 3);
        #1;
        check_comb("coll3");
        chk("coll3.rdat2", rf.rdat2, BYPASS ? 32'hA5A5A5A5 : 32'h1111_1111);
        chk("coll3.busy2", {31'd0, rf.busy2}, BYPASS ? 32'd0 : 32'd1);
        step("coll3.post");

        // Random traffic with biased collisions
        for (int n = 0; n < 400; n++) begin
            ws = 5'($urandom_range(0, 31));
            is = ($urandom_range(0, 3) == 0) ? ws : 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), ws, word_t'($urandom),
                  1'($urandom_range(0, 1)), is,
                  ($urandom_range(0, 2) == 0) ? ws : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? is : 5'($urandom_range(0, 31)));
            #1;
            check_comb("rnd.pre");
            step("rnd");
        end

        // Issue 4 and 6, then assert reset mid-cycle with a pending write/issue
        drive(1, 4, 32'hCAFE_0004, 1, 4, 4, 6);
        step("iss4");
        drive(1, 6, 32'hCAFE_0006, 1, 6, 4, 6);
        step("iss6");
        drive(1, 8, 32'h8888_8888, 1, 8, 4, 6);
        #3;
        rf.nRST = 1'b0;
        model_clear();
        #1;
        chk("rst.cnt", {26'd0, rf.pend_cnt}, 32'd0);
        check_comb("rst.async");
        step("rst.edge");
        rf.nRST = 1'b1;
        drive(0, 0, '0, 0, 0, 8, 4);
        #1;
        check_comb("rst.after");
        chk("rst.rdat8", rf.rdat1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_file_sb.md
# register_file_sb

Two-read, one-write 32 x 32-bit MIPS register file with an integrated pending-write scoreboard. Sits in decode, directly upstream of the ALU: `rdat1`/`rdat2` drive ALU `port_a`/`port_b` through the ID/EX latch. Writeback drives the write port. The scoreboard flags source registers that still have an in-flight writer, so the hazard unit can stall before operands reach the ALU.

## Interface
Parameters:
- `NREGS`, 32, number of architectural registers (select width = `$clog2(NREGS)`).
- `WORD_W`, 32, data width (matches `word_t`).

Ports:
- `CLK`  in  1  system clock, rising-edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `WEN`  in  1  writeback write enable.
- `wsel`  in  5  writeback destination register.
- `wdat`  in  32  writeback data.
- `rsel1`  in  5  read port 1 select.
- `rsel2`  in  5  read port 2 select.
- `rdat1`  out  32  read port 1 data.
- `rdat2`  out  32  read port 2 data.
- `iss_en`  in  1  instruction issued with destination `iss_sel`; marks it pending.
- `iss_sel`  in  5  destination of the issuing instruction.
- `busy1`  out  1  register `rsel1` has a pending writer.
- `busy2`  out  1  register `rsel2` has a pending writer.
- `pend_cnt`  out  6  number of registers currently marked pending.

## Operation
- Storage: `NREGS` words plus a 1-bit pending flag per register.
- Register 0 is hard-wired:
  - reads return 0;
  - writes are ignored;
  - `iss_en` to register 0 is ignored;
  - its pending flag is always 0.
- Write: on a rising edge with `WEN`=1 and `wsel`!=0, `regs[wsel]` <= `wdat` and `pending[wsel]` <= 0.
- Issue: on a rising edge with `iss_en`=1 and `iss_sel`!=0, `pending[iss_sel]` <= 1.
- Same edge, `iss_sel`==`wsel`, both enabled: the data is written and pending ends at 1. Set wins, because a newer writer is in flight.
- Reads are combinational: `rdatN` = `regs[rselN]`, `busyN` = `pending[rselN]`, before bypass.
- `pend_cnt` is a registered counter, updated every edge:
  - +1 if the issue sets a flag that was 0;
  - −1 if the write clears a flag that was 1 and the same edge does not re-set it;
  - net 0 when both happen to different registers.
  - Range 0..31; it never wraps.
- A write to a register whose flag is 0 (e.g. `JAL` writeback without issue tracking) is legal. It only updates data; the counter is unchanged.
- Issuing to an already-pending register leaves the flag at 1 and the counter unchanged.

## Timing
- Reset (`nRST`=0, asynchronous):
  - all registers 0;
  - all pending flags 0;
  - `pend_cnt`=0;
  - consequently `rdat1`=`rdat2`=0 and `busy1`=`busy2`=0.
- Reset asserted mid-operation clears all state immediately; a coincident write or issue is discarded.
- Read latency is 0 cycles (combinational).
- Write latency:
  - data is visible on read ports the cycle after the write edge;
  - the busy flag clears the cycle after the write edge (see Configuration for same-cycle bypass).
- Issue latency: `busyN` rises the cycle after the `iss_en` edge.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: write-first bypass.
  - When `WEN`=1, `wsel`!=0 and `rselN`==`wsel`, `rdatN` = `wdat` combinationally and `busyN` = 0 in the same cycle.
  - If an issue to that register happens on the same edge, `busyN` still reads 0 this cycle.
  - `pend_cnt` is unaffected, since it is registered.
- Not defined: no bypass. The hazard unit must stall one extra cycle on a writeback/read collision.

## Structure
- `cpu_types_pkg` supplies `word_t`, `regbits_t` (5-bit select) and `WORD_W`.
- Add a `REG_ZERO` constant to `cpu_types_pkg`.
- Ports are grouped in a `register_file_sb_if` interface with modports `rf` and `tb`.
- One sub-module: `reg_scoreboard`. It holds the pending flags, `busy1`/`busy2` lookup and `pend_cnt`. It takes the write/issue strobes and the selects.

## Test plan
- Reset, then read all 32 registers → every `rdat` = 0, `busy` = 0, `pend_cnt` = 0.
- Write `0xDEADBEEF` to reg 5; next cycle `rsel1`=5 → `rdat1` = `0xDEADBEEF`. Write `0xFFFFFFFF` to reg 0 → `rdat2` = 0 for `rsel2`=0.
- `iss_en` to reg 7 and reg 9 on consecutive cycles:
  - → `pend_cnt` 1 then 2, and `busy1`=1 for `rsel1`=7.
  - Writeback reg 7 → next cycle `busy1`=0, `pend_cnt`=1.
- Same edge `iss_sel`=`wsel`=12 with `wdat`=`0x1234` → `regs[12]`=`0x1234`, `busy`=1, `pend_cnt` unchanged if reg 12 was already pending.
- With `REGFILE_BYPASS_EN`: `WEN`=1, `wsel`=`rsel2`=3, `wdat`=`0xA5A5A5A5` → same cycle `rdat2`=`0xA5A5A5A5`, `busy2`=0. Without the macro → old value and old busy.
- Issue to regs 4 and 6, then assert `nRST` mid-cycle → outputs clear immediately: `pend_cnt`=0, `busy`=0, `rdat`=0.
